// File: rtl/riscv_fetch_queue.sv
// In-order instruction fetch with a DEPTH-entry PC/instruction queue and redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: flag misaligned redirect targets and stall fetch until an aligned one.
module riscv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [31:0]     if_inst,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready,
    output logic            fetch_misaligned
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic            started_q, started_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            misaligned_q;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic            credit_ok;
    logic            fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_tgt;

    // Queue occupancy plus words in flight may never exceed the queue size.
    assign credit_ok    = ({1'b0, occ_q} + {1'b0, out_q}) < DEPTH_C;
    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    assign imem_req         = started_q & ~redirect_valid & ~misaligned_q & credit_ok;
    assign imem_addr        = fetch_pc_q;
    assign fire             = imem_req & imem_gnt;
    assign if_valid         = (occ_q != '0) & ~redirect_valid;
    assign if_inst          = inst_mem_q[rd_ptr_q];
    assign if_pc            = pc_mem_q[rd_ptr_q];
    assign pop              = if_valid & id_ready;
    assign push             = imem_rvalid & ~redirect_valid & (discard_q == '0);
    assign fetch_misaligned = misaligned_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_d;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            misaligned_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    assign misaligned_q = 1'b0;
`endif

    always_comb begin
        started_d  = 1'b1;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        occ_d      = occ_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_d      = out_q + CW'(fire) - CW'(imem_rvalid);

        if (redirect_valid) begin
            // Everything still in flight is stale, except a word landing right now, which is dropped here.
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = out_q - CW'(imem_rvalid);
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rvalid && discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            occ_q      <= '0;
            out_q      <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            started_q  <= started_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            inst_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // A response with nothing outstanding means the memory side broke the protocol.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_rvalid && out_q == '0));
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Randomized and directed bench for riscv_fetch_queue; reference model tracks expected PC streams per redirect epoch.
module tb_riscv_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        fetch_misaligned;

    always #5 clk = ~clk;

    riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .fetch_misaligned(fetch_misaligned)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] pend_addr[$];
    int          pend_ep[$];
    int          epoch, occ, grants;
    bit          started, mis;
    logic [31:0] exp_fetch, exp_pop;
    bit          o_valid, o_req, o_mis;
    logic [31:0] o_pc, o_inst, o_addr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16]} + 32'h0100_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_addr.delete();
        pend_ep.delete();
        epoch = 0; occ = 0; started = 0; mis = 0;
        exp_fetch = 32'h0; exp_pop = 32'h0;
    endtask

    // mm: 0 = respond every cycle something is pending, 1 = random latency, 2 = hold responses
    task automatic cycle(input bit g, input bit rdy, input bit rd, input logic [31:0] tgt, input int mm);
        bit ereq, evalid, resp, pop;
        int re;
        imem_gnt = g; id_ready = rdy; redirect_valid = rd; redirect_pc = tgt;
        resp = (pend_addr.size() > 0) && (mm == 0 || (mm == 1 && $urandom_range(0, 2) != 0));
        imem_rvalid = resp;
        imem_rdata  = resp ? word(pend_addr[0]) : 32'hdead_beef;
        #1;
        ereq   = started && !rd && !mis && (occ + pend_addr.size() < DEPTH);
        evalid = (occ > 0) && !rd;
        chk("imem_req", 32'(imem_req), 32'(ereq));
        if (ereq) chk("imem_addr", imem_addr, exp_fetch);
        chk("if_valid", 32'(if_valid), 32'(evalid));
        if (evalid) begin
            chk("if_pc", if_pc, exp_pop);
            chk("if_inst", if_inst, word(exp_pop));
        end
        chk("fetch_misaligned", 32'(fetch_misaligned), 32'(mis));
        o_valid = if_valid; o_req = imem_req; o_mis = fetch_misaligned;
        o_pc = if_pc; o_inst = if_inst; o_addr = imem_addr;
        pop = evalid && rdy;
        @(posedge clk);
        if (ereq && g) begin
            pend_addr.push_back(exp_fetch);
            pend_ep.push_back(epoch);
            exp_fetch += 32'd4;
            grants++;
        end
        if (resp) begin
            void'(pend_addr.pop_front());
            re = pend_ep.pop_front();
            if (!rd && re == epoch) occ++;
        end
        if (pop) begin
            occ--;
            exp_pop += 32'd4;
        end
        if (rd) begin
            epoch++;
            occ = 0;
            exp_fetch = tgt & ~32'h3;
            exp_pop   = tgt & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis = (tgt[1:0] != 2'b00);
`endif
        end
        started = 1;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  first, nvalid;
        bit  found;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect_valid = 0;
        redirect_pc = 0; id_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_misaligned", 32'(fetch_misaligned), 32'h0);
        rst_n = 1'b1;

        // Streaming from reset: first head three cycles after release, then one per cycle
        first = -1; nvalid = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1, 1, 0, 32'h0, 0);
            if (o_valid && first < 0) first = i;
            if (o_valid) nvalid++;
        end
        chk("t1_first_valid_cycle", 32'(first), 32'd3);
        chk("t1_valid_count", 32'(nvalid), 32'd11);

        // Decode stalled: exactly DEPTH grants, then fetch stops until decode drains
        cycle(0, 1, 1, 32'h200, 0);
        grants = 0;
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 32'h0, 0);
        chk("t2_grants", 32'(grants), 32'(DEPTH));
        chk("t2_req_stopped", 32'(o_req), 32'h0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 32'h0, 0);
        chk("t2_req_resumed", 32'(o_req), 32'h1);

        // Two requests in flight when redirected: both dropped
        for (int i = 0; i < 20 && pend_addr.size() < 2; i++) cycle(1, 1, 0, 32'h0, 2);
        chk("t3_outstanding", 32'(pend_addr.size()), 32'd2);
        cycle(0, 1, 1, 32'h100, 2);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1, 0, 0, 32'h0, 0);
            found = o_valid;
        end
        chk("t3_found", 32'(found), 32'h1);
        chk("t3_pc", o_pc, 32'h100);
        chk("t3_inst", o_inst, word(32'h100));

        // Redirect landing on the same cycle as a response and a ready decode
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 32'h0, 0);
        chk("t4_rsp_pending", 32'(pend_addr.size() > 0), 32'h1);
        cycle(1, 1, 1, 32'h300, 0);
        chk("t4_if_valid", 32'(o_valid), 32'h0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 32'h0, 0);

        // Grant withheld: request held steady, queue drains
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h0, 0);
        chk("t5_req_held", 32'(o_req), 32'h1);
        chk("t5_drained", 32'(o_valid), 32'h0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'h0, 0);

        // Misaligned redirect target
        cycle(1, 1, 1, 32'h102, 0);
        cycle(1, 1, 0, 32'h0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("t6_flag_set", 32'(o_mis), 32'h1);
        chk("t6_req_blocked", 32'(o_req), 32'h0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 1, 1, 32'h104, 0);
        cycle(1, 1, 0, 32'h0, 0);
        chk("t6_flag_clear", 32'(o_mis), 32'h0);
        chk("t6_addr", o_addr, 32'h104);
`else
        chk("t6_addr", o_addr, 32'h100);
        chk("t6_flag_tied", 32'(o_mis), 32'h0);
`endif
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 32'h0, 0);

        // Wrap at the top of the address space
        cycle(1, 1, 1, 32'hffff_fff8, 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 32'h0, 0);

        // Reset in mid-stream clears everything
        rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; id_ready = 0; redirect_valid = 0;
        #1;
        chk("mid_rst_if_valid", 32'(if_valid), 32'h0);
        chk("mid_rst_imem_req", 32'(imem_req), 32'h0);
        chk("mid_rst_if_pc", if_pc, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t = t & 32'h0000_fffc;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, t, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
